// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Reset sequencer for FPGA top levels. It holds every downstream reset domain
//   in reset until the clock source is locked and a hold time has elapsed. It
//   then releases the domains one at a time, with channel 0 first. It returns to
//   reset on a debounced external request, a software request (only in RUN), or
//   a lock loss (only when the monitor is enabled). It also reports the cause of
//   the last reset.
//
//   Optional feature macro: RST_SEQ_LOCK_MONITOR_EN
//     defined   - lock loss in HOLD/RELEASE/RUN is a reset event (cause 01)
//     undefined - lock only gates the WAIT exit; later lock loss is ignored
//
// Ports
//   clk_i          in   free-running clock
//   rst_ni         in   asynchronous active-low power-on reset
//   pll_locked_i   in   clock generator lock (async, 2-flop synchronised)
//   ext_rst_req_i  in   external reset request (async, synchronised + debounced)
//   sw_rst_req_i   in   synchronous single-cycle software reset pulse
//   rst_no         out  per-domain active-low resets, bit 0 released first
//   rst_done_o     out  high in RUN once every channel is released
//   rst_cause_o    out  last reset cause: 00 POR, 01 lock loss, 10 ext, 11 sw
module rst_sequencer #(
    parameter int NumOut         = 2,
    parameter int HoldCycles     = 1000,
    parameter int StageGap       = 16,
    parameter int DebounceCycles = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pll_locked_i,
    input  logic              ext_rst_req_i,
    input  logic              sw_rst_req_i,
    output logic [NumOut-1:0] rst_no,
    output logic              rst_done_o,
    output logic [1:0]        rst_cause_o
);

    localparam int MaxHg  = (HoldCycles > StageGap) ? HoldCycles : StageGap;
    localparam int MaxCnt = (MaxHg > DebounceCycles) ? MaxHg : DebounceCycles;
    localparam int CntW   = $clog2(MaxCnt + 1);
    localparam int ChW    = (NumOut > 1) ? $clog2(NumOut) : 1;

    localparam logic [CntW-1:0]   HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0]   GapLast  = CntW'(StageGap - 1);
    localparam logic [CntW-1:0]   DebTerm  = CntW'(DebounceCycles);
    localparam logic [ChW-1:0]    ChLast   = ChW'(NumOut - 1);
    localparam logic [NumOut-1:0] ChOne    = NumOut'(1);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    logic              lock_meta_q, lock_sync_q;
    logic              ext_meta_q, ext_sync_q;
    logic [CntW-1:0]   deb_cnt_q, deb_cnt_d;
    logic              ext_req_q;
    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ChW-1:0]    ch_q;
    logic [NumOut-1:0] rst_q;
    logic              done_q;
    logic [1:0]        cause_q;
    logic              lock_loss;
    logic              evt;
    logic [1:0]        evt_cause;

    // Two-flop synchronisers for the asynchronous inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            ext_meta_q  <= 1'b0;
            ext_sync_q  <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked_i;
            lock_sync_q <= lock_meta_q;
            ext_meta_q  <= ext_rst_req_i;
            ext_sync_q  <= ext_meta_q;
        end
    end

    // Debounce: count consecutive synced-high samples. The count saturates at the
    // terminal value so the request stays asserted while the input is held.
    always_comb begin
        deb_cnt_d = '0;
        if (ext_sync_q) begin
            deb_cnt_d = (deb_cnt_q == DebTerm) ? deb_cnt_q : deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_cnt_q <= '0;
            ext_req_q <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            ext_req_q <= (deb_cnt_d == DebTerm);
        end
    end

`ifdef RST_SEQ_LOCK_MONITOR_EN
    assign lock_loss = ~lock_sync_q;
`else
    assign lock_loss = 1'b0;
`endif

    // Reset events are taken only outside WAIT. The cause priority is
    // lock loss > external > software.
    always_comb begin
        evt       = 1'b0;
        evt_cause = 2'b00;
        if (state_q != ST_WAIT) begin
            if (lock_loss) begin
                evt       = 1'b1;
                evt_cause = 2'b01;
            end else if (ext_req_q) begin
                evt       = 1'b1;
                evt_cause = 2'b10;
            end else if ((state_q == ST_RUN) && sw_rst_req_i) begin
                evt       = 1'b1;
                evt_cause = 2'b11;
            end
        end
    end

    // The sequencer FSM. All outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= 2'b00;
        end else if (evt) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= evt_cause;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (lock_sync_q && !ext_req_q) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HoldLast) begin
                        cnt_q    <= '0;
                        rst_q[0] <= 1'b1;
                        // With a single channel, the first release is also the last one.
                        if (NumOut == 1) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                            ch_q    <= ChW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GapLast) begin
                        cnt_q <= '0;
                        rst_q <= rst_q | (ChOne << ch_q);
                        if (ch_q == ChLast) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign rst_no      = rst_q;
    assign rst_done_o  = done_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

`ifdef RST_SEQ_LOCK_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       ext;
    logic       sw;
    logic [2:0] rst_no;
    logic       done;
    logic [1:0] cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NumOut        (3),
        .HoldCycles    (1000),
        .StageGap      (16),
        .DebounceCycles(64)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pll_locked_i (lock),
        .ext_rst_req_i(ext),
        .sw_rst_req_i (sw),
        .rst_no       (rst_no),
        .rst_done_o   (done),
        .rst_cause_o  (cause)
    );

    typedef struct {
        logic       lock;
        logic       ext;
        logic       sw;
        int         adv;
        logic [2:0] rst;
        logic       done;
        logic [1:0] cause;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic l, input logic e, input logic s, input int n,
                       input logic [2:0] r, input logic d, input logic [1:0] c,
                       input string nm);
        vec_t v;
        v.lock = l; v.ext = e; v.sw = s; v.adv = n;
        v.rst = r; v.done = d; v.cause = c; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [2:0] er, input logic ed,
                         input logic [1:0] ec);
        checks++;
        if (rst_no !== er || done !== ed || cause !== ec) begin
            errors++;
            $display("FAIL %s: got rst_no=%b done=%b cause=%b, required rst_no=%b done=%b cause=%b",
                     nm, rst_no, done, cause, er, ed, ec);
        end else begin
            $display("ok   %s: rst_no=%b done=%b cause=%b", nm, rst_no, done, cause);
        end
    endtask

    initial begin
        // Power-on sequence, debounce, software request and lock-loss vectors.
        add(1, 0, 0, 3,    3'b000, 0, 2'b00, "hold_entry");
        add(1, 0, 0, 999,  3'b000, 0, 2'b00, "before_rel0");
        add(1, 0, 0, 1,    3'b001, 0, 2'b00, "rel0");
        add(1, 0, 0, 15,   3'b001, 0, 2'b00, "before_rel1");
        add(1, 0, 0, 1,    3'b011, 0, 2'b00, "rel1");
        add(1, 0, 0, 15,   3'b011, 0, 2'b00, "before_rel2");
        add(1, 0, 0, 1,    3'b111, 1, 2'b00, "rel2_done");
        add(1, 0, 0, 10,   3'b111, 1, 2'b00, "run_steady");
        add(1, 1, 0, 63,   3'b111, 1, 2'b00, "ext63_held");
        add(1, 0, 0, 10,   3'b111, 1, 2'b00, "ext63_no_reset");
        add(1, 1, 0, 66,   3'b111, 1, 2'b00, "ext_debounced");
        add(1, 1, 0, 1,    3'b000, 0, 2'b10, "ext_event");
        add(1, 1, 0, 20,   3'b000, 0, 2'b10, "ext_held_wait");
        add(1, 0, 0, 4,    3'b000, 0, 2'b10, "ext_release_hold");
        add(1, 0, 1, 1,    3'b000, 0, 2'b10, "sw_in_hold_ignored");
        add(1, 0, 0, 998,  3'b000, 0, 2'b10, "before_rel0_b");
        add(1, 0, 0, 1,    3'b001, 0, 2'b10, "rel0_b");
        add(1, 0, 0, 32,   3'b111, 1, 2'b10, "rel2_b");
        add(1, 0, 1, 1,    3'b000, 0, 2'b11, "sw_in_run");
        add(1, 0, 0, 1000, 3'b000, 0, 2'b11, "before_rel0_c");
        add(1, 0, 0, 1,    3'b001, 0, 2'b11, "rel0_c");
        add(0, 0, 0, 3,    MON ? 3'b000 : 3'b001, 1'b0, MON ? 2'b01 : 2'b11, "lock_drop");
        add(0, 0, 0, 20,   MON ? 3'b000 : 3'b011, 1'b0, MON ? 2'b01 : 2'b11, "lock_low");
        add(1, 0, 0, 3,    MON ? 3'b000 : 3'b011, 1'b0, MON ? 2'b01 : 2'b11, "lock_back");
        add(1, 0, 0, 1000, MON ? 3'b001 : 3'b111, MON ? 1'b0 : 1'b1, MON ? 2'b01 : 2'b11, "after_lock_back");
        add(1, 0, 0, 32,   3'b111, 1'b1, MON ? 2'b01 : 2'b11, "run_after_lock");

        rst_n = 1'b0;
        lock  = 1'b1;
        ext   = 1'b0;
        sw    = 1'b0;
        step(3);
        check("reset_state", 3'b000, 1'b0, 2'b00);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            lock = vecs[i].lock;
            ext  = vecs[i].ext;
            sw   = vecs[i].sw;
            step(vecs[i].adv);
            check(vecs[i].name, vecs[i].rst, vecs[i].done, vecs[i].cause);
        end
        sw = 1'b0;

        // Lock drop and debounce completion land on the same cycle.
        ext = 1'b1;
        step(64);
        lock = 1'b0;
        step(3);
        check("coincident_events", 3'b000, 1'b0, MON ? 2'b01 : 2'b10);

        // Recover, then assert rst_ni in the middle of RELEASE.
        lock = 1'b1;
        ext  = 1'b0;
        step(1004);
        check("recover_rel0", 3'b001, 1'b0, MON ? 2'b01 : 2'b10);
        step(5);
        rst_n = 1'b0;
        #2;
        check("por_async", 3'b000, 1'b0, 2'b00);
        step(2);
        check("por_held", 3'b000, 1'b0, 2'b00);
        rst_n = 1'b1;
        step(1002);
        check("por_before_rel0", 3'b000, 1'b0, 2'b00);
        step(1);
        check("por_rel0", 3'b001, 1'b0, 2'b00);
        step(32);
        check("por_done", 3'b111, 1'b1, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
